dsp_config_bank: RTL and testbench

Multi-channel configuration register bank for the DSP accelerator chiplet. It holds one CFG_W-bit mode word per processing channel in a host-writable shadow bank, and transfers all shadow words atomically into the active bank on a commit. The transfer waits for a datapath frame boundary (or applies immediately, per parameter), so channel modes never change mid-frame. The block also provides addressed readback, write lock and error reporting.

---
 rtl/dsp_config_bank.sv | 112 +++++++++++
 tb/tb_dsp_config_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_config_bank.sv
// rtl/dsp_config_bank.sv - per-channel shadow/active config bank with frame-synchronous commit
module dsp_config_bank #(
    parameter int               NUM_CH      = 4,
    parameter int               CFG_W       = 5,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = '0,
    parameter bit               SYNC_APPLY  = 1'b1,
    localparam int              AW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [CFG_W-1:0]         wr_data,
    input  logic                     lock,
    input  logic                     commit_req,
    input  logic                     frame_sync,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    input  logic                     rd_src,
    output logic [CFG_W-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     wr_err,
    output logic [NUM_CH-1:0]        dirty,
    output logic                     busy,
    output logic                     apply_done,
    output logic [NUM_CH*CFG_W-1:0]  cfg_active
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t           state;
    logic [CFG_W-1:0] shadow [NUM_CH];
    logic [CFG_W-1:0] active [NUM_CH];
    logic             wr_ok;
    logic [CFG_W-1:0] rd_word;

    // Write acceptance and readback mux; out-of-range reads return zero
    always_comb begin
        wr_ok   = wr_en && !lock && (32'(wr_addr) < NUM_CH);
        rd_word = '0;
        if (32'(rd_addr) < NUM_CH) begin
            rd_word = rd_src ? active[rd_addr] : shadow[rd_addr];
        end
    end

    // Commit sequencer: APPLY lasts one cycle and may re-arm straight away on a new commit_req
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            apply_done <= 1'b0;
        end else begin
            apply_done <= (state == APPLY);
            case (state)
                IDLE:    if (commit_req) state <= SYNC_APPLY ? PENDING : APPLY;
                PENDING: if (frame_sync) state <= APPLY;
                APPLY:   state <= commit_req ? (SYNC_APPLY ? PENDING : APPLY) : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Shadow/active banks and dirty flags; a write on the apply edge wins over the dirty clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                shadow[i] <= DEFAULT_CFG;
                active[i] <= DEFAULT_CFG;
                dirty[i]  <= 1'b0;
            end else begin
                if (state == APPLY) begin
                    active[i] <= shadow[i];
                end
                if (wr_ok && (32'(wr_addr) == i)) begin
                    shadow[i] <= wr_data;
                    dirty[i]  <= 1'b1;
                end else if (state == APPLY) begin
                    dirty[i]  <= 1'b0;
                end
            end
        end
    end

    // Registered readback and write-reject pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            wr_err   <= wr_en && !wr_ok;
            if (rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

    // Flatten the active bank, channel 0 in the LSBs
    always_comb begin
        cfg_active = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_active[i*CFG_W +: CFG_W] = active[i];
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dsp_config_bank.sv
// tb/tb_dsp_config_bank.sv - scoreboard bench for dsp_config_bank (synchronous and immediate-apply builds)
module tb_dsp_config_bank;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic       lock;
    logic       commit_req;
    logic       frame_sync;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic       rd_src;

    logic [4:0]  rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        wr_err0, wr_err1;
    logic [3:0]  dirty0;
    logic [2:0]  dirty1;
    logic        busy0, busy1;
    logic        apply_done0, apply_done1;
    logic [19:0] cfg_active0;
    logic [14:0] cfg_active1;

    dsp_config_bank #(.NUM_CH(4), .CFG_W(5), .DEFAULT_CFG(5'b00000), .SYNC_APPLY(1'b1)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lock(lock), .commit_req(commit_req), .frame_sync(frame_sync), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_src(rd_src), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .wr_err(wr_err0), .dirty(dirty0), .busy(busy0), .apply_done(apply_done0),
        .cfg_active(cfg_active0)
    );

    dsp_config_bank #(.NUM_CH(3), .CFG_W(5), .DEFAULT_CFG(5'b00000), .SYNC_APPLY(1'b0)) u_dut_imm (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lock(lock), .commit_req(commit_req), .frame_sync(frame_sync), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_src(rd_src), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .wr_err(wr_err1), .dirty(dirty1), .busy(busy1), .apply_done(apply_done1),
        .cfg_active(cfg_active1)
    );

    typedef struct {
        logic [3:0]  dirty;
        logic        busy;
        logic [19:0] act;
        logic        wr_err;
        logic        apply_done;
        logic        rd_valid;
    } snap_t;

    snap_t      snap_q0[$];
    snap_t      snap_q1[$];
    logic [4:0] rd_q0[$];
    logic [4:0] rd_q1[$];

    // Reference model: commit progress is tracked as "idle", "waiting for frame", "applying now"
    localparam int M_IDLE = 0, M_WAIT = 1, M_APPLY = 2;
    logic [4:0] m_sh [2][4];
    logic [4:0] m_ac [2][4];
    logic [3:0] m_dirty [2];
    int         m_st [2];
    int         nch [2];
    bit         syn [2];

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        snap_t s;
        int    a;
        int    r;
        bit    acc;
        bit    applying;
        logic [4:0] v;
        s.wr_err = 1'b0; s.apply_done = 1'b0; s.rd_valid = 1'b0;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_sh[k][i] = 5'd0;
                m_ac[k][i] = 5'd0;
            end
            m_dirty[k] = 4'd0;
            m_st[k]    = M_IDLE;
        end else begin
            a        = int'(wr_addr);
            r        = int'(rd_addr);
            acc      = wr_en && !lock && (a < nch[k]);
            applying = (m_st[k] == M_APPLY);
            if (rd_en) begin
                v = 5'd0;
                if (r < nch[k]) v = rd_src ? m_ac[k][r] : m_sh[k][r];
                if (k == 0) rd_q0.push_back(v); else rd_q1.push_back(v);
            end
            s.rd_valid   = rd_en;
            s.wr_err     = wr_en && !acc;
            s.apply_done = applying;
            if (applying) begin
                for (int i = 0; i < 4; i++) m_ac[k][i] = m_sh[k][i];
                m_dirty[k] = 4'd0;
            end
            if (acc) begin
                m_sh[k][a]    = wr_data;
                m_dirty[k][a] = 1'b1;
            end
            if (m_st[k] == M_WAIT) begin
                if (frame_sync) m_st[k] = M_APPLY;
            end else if (commit_req) begin
                m_st[k] = syn[k] ? M_WAIT : M_APPLY;
            end else begin
                m_st[k] = M_IDLE;
            end
        end
        s.dirty = m_dirty[k];
        s.busy  = (m_st[k] != M_IDLE);
        s.act   = 20'd0;
        for (int i = 0; i < nch[k]; i++) s.act[i*5 +: 5] = m_ac[k][i];
        if (k == 0) snap_q0.push_back(s); else snap_q1.push_back(s);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] wa, input logic [4:0] wd,
                         input logic lk, input logic cr, input logic fs,
                         input logic re, input logic [1:0] ra, input logic rs);
        @(negedge clk);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; lock = lk;
        commit_req = cr; frame_sync = fs; rd_en = re; rd_addr = ra; rd_src = rs;
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    // Monitor: pops the expected post-edge snapshot and any expected readback, 1 time unit after the edge
    always @(posedge clk) begin : monitor
        snap_t s;
        #1;
        if (snap_q0.size() > 0) begin
            s = snap_q0.pop_front();
            check("sync_dirty", 32'(dirty0), 32'(s.dirty));
            check("sync_busy", 32'(busy0), 32'(s.busy));
            check("sync_cfg_active", 32'(cfg_active0), 32'(s.act));
            check("sync_wr_err", 32'(wr_err0), 32'(s.wr_err));
            check("sync_apply_done", 32'(apply_done0), 32'(s.apply_done));
            check("sync_rd_valid", 32'(rd_valid0), 32'(s.rd_valid));
            if (rd_valid0 === 1'b1) begin
                if (rd_q0.size() == 0) check("sync_rd_unexpected", 32'(rd_valid0), 32'd0);
                else check("sync_rd_data", 32'(rd_data0), 32'(rd_q0.pop_front()));
            end
        end
        if (snap_q1.size() > 0) begin
            s = snap_q1.pop_front();
            check("imm_dirty", 32'(dirty1), 32'(s.dirty[2:0]));
            check("imm_busy", 32'(busy1), 32'(s.busy));
            check("imm_cfg_active", 32'(cfg_active1), 32'(s.act[14:0]));
            check("imm_wr_err", 32'(wr_err1), 32'(s.wr_err));
            check("imm_apply_done", 32'(apply_done1), 32'(s.apply_done));
            check("imm_rd_valid", 32'(rd_valid1), 32'(s.rd_valid));
            if (rd_valid1 === 1'b1) begin
                if (rd_q1.size() == 0) check("imm_rd_unexpected", 32'(rd_valid1), 32'd0);
                else check("imm_rd_data", 32'(rd_data1), 32'(rd_q1.pop_front()));
            end
        end
    end

    initial begin
        nch[0] = 4; syn[0] = 1'b1;
        nch[1] = 3; syn[1] = 1'b0;
        reset = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; lock = 0;
        commit_req = 0; frame_sync = 0; rd_en = 0; rd_addr = 0; rd_src = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin m_sh[k][i] = 5'd0; m_ac[k][i] = 5'd0; end
            m_dirty[k] = 4'd0; m_st[k] = M_IDLE;
        end

        // reset, then read back every active word
        drive(1, 0, 2'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0);
        drive(1, 0, 2'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 1, 2'(i), 1);

        // write ch2, commit, frame boundary a few cycles later
        drive(0, 1, 2'd2, 5'h13, 0, 0, 0, 0, 2'd0, 0);
        idle(2);
        drive(0, 0, 2'd0, 5'd0, 0, 1, 0, 0, 2'd0, 0);
        idle(4);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 1, 0, 2'd0, 0);
        idle(2);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 1, 2'd2, 1);

        // locked write, then out-of-range write for the 3-channel build
        drive(0, 1, 2'd1, 5'h1F, 1, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 1, 2'd1, 0);
        drive(0, 1, 2'd3, 5'h11, 0, 0, 0, 1, 2'd3, 0);
        idle(1);

        // write landing on the apply edge
        drive(0, 1, 2'd0, 5'h0A, 0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 1, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 1, 0, 2'd0, 0);
        drive(0, 1, 2'd0, 5'h05, 0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 1, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 0, 1, 2'd0, 1);

        // reset while a commit is pending aborts it
        drive(1, 0, 2'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0);
        idle(1);
        drive(0, 0, 2'd0, 5'd0, 0, 1, 0, 0, 2'd0, 0);
        idle(2);
        drive(1, 0, 2'd0, 5'd0, 0, 0, 0, 0, 2'd0, 0);
        idle(1);
        drive(0, 0, 2'd0, 5'd0, 0, 0, 1, 0, 2'd0, 0);
        idle(3);

        // immediate-apply path exercised by back-to-back commits
        drive(0, 1, 2'd2, 5'h07, 0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 1, 0, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 5'd0, 0, 1, 1, 0, 2'd0, 0);
        idle(3);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 199) < 2,
                  $urandom_range(0, 99) < 40, 2'($urandom_range(0, 3)), 5'($urandom),
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)), 1'($urandom));
        end
        idle(1);
        @(posedge clk);
        #3;
        check("sync_queue_drained", 32'(snap_q0.size() + rd_q0.size()), 32'd0);
        check("imm_queue_drained", 32'(snap_q1.size() + rd_q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
